// File: rtl/uart_frame_loader.sv
// Frame parser and multi-channel word buffer behind a UART byte core.
// Loads checksummed frames into per-channel buffers, replies ACK/NAK, and streams a loaded channel out.
module uart_frame_loader #(
    parameter int unsigned D_WL        = 24,
    parameter int unsigned DEPTH       = 20,
    parameter int unsigned N_CH        = 2,
    parameter logic [7:0]  HDR         = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     load_en,
    input  logic [7:0]                               rx_data,
    input  logic                                     rx_finish,
    output logic [7:0]                               tx_data,
    output logic                                     tx_en,
    output logic                                     frame_err,
    output logic [N_CH-1:0]                          ch_valid,
    input  logic                                     rd_start,
    input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] rd_ch,
    output logic                                     rd_busy,
    output logic [D_WL-1:0]                          d_o,
    output logic                                     d_o_valid,
    input  logic                                     d_o_ready,
    output logic                                     d_o_last
);

    localparam int unsigned BYTES = (D_WL + 7) / 8;
    localparam int unsigned WB    = BYTES * 8;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CH   = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] CSUM = 2'd3;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [7:0]      csum_q, csum_d;
    logic [WB-1:0]   word_q, word_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]   word_cnt_q, word_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [N_CH-1:0] ch_valid_q, ch_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_en_q, tx_en_d;
    logic            frame_err_q, frame_err_d;

    logic            rd_busy_q, rd_busy_d;
    logic [CW-1:0]   rd_ch_q, rd_ch_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [D_WL-1:0] d_o_q, d_o_d;
    logic            d_o_valid_q, d_o_valid_d;
    logic            d_o_last_q, d_o_last_d;

    logic [D_WL-1:0] mem_q [N_CH][DEPTH];

    logic            rx_acc_c;
    logic            tmo_hit_c;
    logic [WB-1:0]   word_shift_c;
    logic            mem_we_c;
    logic [AW-1:0]   rd_addr_nx_c;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        csum_d       = csum_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        tmo_d        = tmo_q;
        ch_valid_d   = ch_valid_q;
        tx_data_d    = '0;
        tx_en_d      = 1'b0;
        frame_err_d  = 1'b0;
        mem_we_c     = 1'b0;
        rx_acc_c     = rx_finish & load_en;
        word_shift_c = (word_q << 8) | WB'(rx_data);
        tmo_hit_c    = load_en && (state_q != IDLE) && !rx_acc_c
                       && (tmo_q == TW'(TIMEOUT_CYC - 1));

        // Inter-byte idle counter: runs only inside a frame and only while loading is enabled
        if (load_en && (state_q != IDLE)) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (rx_acc_c) begin
            tmo_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (rx_acc_c && (rx_data == HDR)) begin
                    state_d = CH;
                end
            end
            CH: begin
                if (rx_acc_c) begin
                    // Refuse unknown channels and the channel currently being streamed
                    if ((rx_data >= 8'(N_CH)) || (rd_busy_q && (rx_data == 8'(rd_ch_q)))) begin
                        tx_data_d   = NAK;
                        tx_en_d     = 1'b1;
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        ch_d                       = CW'(rx_data);
                        ch_valid_d[CW'(rx_data)]   = 1'b0;
                        csum_d                     = rx_data;
                        byte_cnt_d                 = '0;
                        word_cnt_d                 = '0;
                        state_d                    = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_acc_c) begin
                    word_d = word_shift_c;
                    csum_d = csum_q ^ rx_data;
                    if (byte_cnt_q == BW'(BYTES - 1)) begin
                        mem_we_c   = 1'b1;
                        byte_cnt_d = '0;
                        if (word_cnt_q == AW'(DEPTH - 1)) begin
                            state_d = CSUM;
                        end else begin
                            word_cnt_d = word_cnt_q + AW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
            CSUM: begin
                if (rx_acc_c) begin
                    tx_en_d = 1'b1;
                    if (rx_data == csum_q) begin
                        tx_data_d        = ACK;
                        ch_valid_d[ch_q] = 1'b1;
                    end else begin
                        tx_data_d   = NAK;
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tmo_hit_c) begin
            tx_data_d   = NAK;
            tx_en_d     = 1'b1;
            frame_err_d = 1'b1;
            tmo_d       = '0;
            state_d     = IDLE;
        end
    end

    // Stream engine: registered read port, one word per accepted handshake
    always_comb begin
        rd_busy_d    = rd_busy_q;
        rd_ch_d      = rd_ch_q;
        rd_addr_d    = rd_addr_q;
        d_o_d        = d_o_q;
        d_o_valid_d  = d_o_valid_q;
        d_o_last_d   = d_o_last_q;
        rd_addr_nx_c = rd_addr_q + AW'(1);

        if (!rd_busy_q) begin
            if (rd_start && (32'(rd_ch) < N_CH) && ch_valid_q[rd_ch]) begin
                rd_busy_d   = 1'b1;
                rd_ch_d     = rd_ch;
                rd_addr_d   = '0;
                d_o_d       = mem_q[rd_ch][0];
                d_o_valid_d = 1'b1;
                d_o_last_d  = (DEPTH == 1);
            end
        end else if (d_o_valid_q && d_o_ready) begin
            if (d_o_last_q) begin
                rd_busy_d   = 1'b0;
                d_o_valid_d = 1'b0;
                d_o_last_d  = 1'b0;
            end else begin
                rd_addr_d  = rd_addr_nx_c;
                d_o_d      = mem_q[rd_ch_q][rd_addr_nx_c];
                d_o_last_d = (rd_addr_nx_c == AW'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            tmo_q       <= '0;
            ch_valid_q  <= '0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            rd_busy_q   <= 1'b0;
            rd_ch_q     <= '0;
            rd_addr_q   <= '0;
            d_o_q       <= '0;
            d_o_valid_q <= 1'b0;
            d_o_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            tmo_q       <= tmo_d;
            ch_valid_q  <= ch_valid_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            frame_err_q <= frame_err_d;
            rd_busy_q   <= rd_busy_d;
            rd_ch_q     <= rd_ch_d;
            rd_addr_q   <= rd_addr_d;
            d_o_q       <= d_o_d;
            d_o_valid_q <= d_o_valid_d;
            d_o_last_q  <= d_o_last_d;
        end
    end

    // Buffer storage carries no reset; contents are only trusted once ch_valid is set
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[ch_q][word_cnt_q] <= word_shift_c[D_WL-1:0];
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign frame_err = frame_err_q;
    assign ch_valid  = ch_valid_q;
    assign rd_busy   = rd_busy_q;
    assign d_o       = d_o_q;
    assign d_o_valid = d_o_valid_q;
    assign d_o_last  = d_o_last_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: framing, replies, timeout, gating and streaming.
module tb_uart_frame_loader;

    localparam int unsigned D_WL        = 24;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned N_CH        = 2;
    localparam int unsigned TIMEOUT_CYC = 1000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_en;
    logic [7:0]      rx_data;
    logic            rx_finish;
    logic [7:0]      tx_data;
    logic            tx_en;
    logic            frame_err;
    logic [N_CH-1:0] ch_valid;
    logic            rd_start;
    logic [0:0]      rd_ch;
    logic            rd_busy;
    logic [D_WL-1:0] d_o;
    logic            d_o_valid;
    logic            d_o_ready;
    logic            d_o_last;

    int n_vec    = 0;
    int n_err    = 0;
    int tx_cnt   = 0;
    int ferr_cnt = 0;

    logic [23:0] exp_w [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};

    uart_frame_loader #(
        .D_WL(D_WL), .DEPTH(DEPTH), .N_CH(N_CH), .HDR(8'hA5), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .rx_data(rx_data),
        .rx_finish(rx_finish), .tx_data(tx_data), .tx_en(tx_en), .frame_err(frame_err),
        .ch_valid(ch_valid), .rd_start(rd_start), .rd_ch(rd_ch), .rd_busy(rd_busy),
        .d_o(d_o), .d_o_valid(d_o_valid), .d_o_ready(d_o_ready), .d_o_last(d_o_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_en) tx_cnt++;
        if (frame_err) ferr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data   = b;
        rx_finish = 1'b1;
        tick();
        rx_finish = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(ch);
        for (int k = 0; k < 12; k++) send_byte(8'(k + 1));
        send_byte(cs);
    endtask

    task automatic start_rd(input logic ch);
        tick();
        rd_ch    = ch;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        rst_n = 1'b0;
        #3;
        n_vec++;
        if ({tx_data, tx_en, frame_err, ch_valid, rd_busy, d_o, d_o_valid, d_o_last} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero outputs, ch_valid=%b tx_en=%b", ch_valid, tx_en);
        end
        tick();
        rst_n = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        c0 = tx_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tx_data, tx_en, frame_err, ch_valid, rd_busy, d_o_valid, d_o_last} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_data: ch_valid=%b tx_en=%b rd_busy=%b", ch_valid, tx_en, rd_busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if (tx_cnt !== c0) begin
            n_err++;
            $display("FAIL reset_no_reply: got %0d replies, expected %0d", tx_cnt, c0);
        end
    endtask

    task automatic test_load_stream();
        int c0;
        c0 = tx_cnt;
        send_frame(8'h01, 8'h0D);
        n_vec++;
        if ({tx_en, tx_data, frame_err} !== {1'b1, 8'h06, 1'b0}) begin
            n_err++;
            $display("FAIL ack_reply: got en=%b data=%h ferr=%b, expected 1 06 0", tx_en, tx_data, frame_err);
        end
        tick();
        tick();
        n_vec++;
        if (tx_cnt - c0 !== 1) begin
            n_err++;
            $display("FAIL ack_once: got %0d pulses, expected 1", tx_cnt - c0);
        end
        n_vec++;
        if (ch_valid !== 2'b10) begin
            n_err++;
            $display("FAIL ch_valid_after_ack: got %b, expected 10", ch_valid);
        end
        d_o_ready = 1'b1;
        start_rd(1'b1);
        for (int w = 0; w < 4; w++) begin
            n_vec++;
            if ({rd_busy, d_o_valid, d_o, d_o_last} !== {1'b1, 1'b1, exp_w[w], (w == 3)}) begin
                n_err++;
                $display("FAIL stream_word%0d: got busy=%b v=%b d=%h last=%b, expected 1 1 %h %b",
                         w, rd_busy, d_o_valid, d_o, d_o_last, exp_w[w], (w == 3));
            end
            tick();
        end
        n_vec++;
        if ({rd_busy, d_o_valid, d_o_last} !== 3'b000) begin
            n_err++;
            $display("FAIL stream_end: got busy/valid/last=%b, expected 000", {rd_busy, d_o_valid, d_o_last});
        end
    endtask

    task automatic test_bad_csum();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h01, 8'h00);
        n_vec++;
        if ({tx_en, tx_data, frame_err} !== {1'b1, 8'h15, 1'b1}) begin
            n_err++;
            $display("FAIL nak_csum: got en=%b data=%h ferr=%b, expected 1 15 1", tx_en, tx_data, frame_err);
        end
        n_vec++;
        if (ch_valid !== 2'b00) begin
            n_err++;
            $display("FAIL ch_valid_after_nak: got %b, expected 00", ch_valid);
        end
        start_rd(1'b1);
        tick();
        n_vec++;
        if ({rd_busy, d_o_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rd_start_ignored: got busy/valid=%b, expected 00", {rd_busy, d_o_valid});
        end
        n_vec++;
        if (ferr_cnt - f0 !== 1) begin
            n_err++;
            $display("FAIL ferr_once: got %0d pulses, expected 1", ferr_cnt - f0);
        end
    endtask

    task automatic test_stall();
        int hs;
        hs = 0;
        send_frame(8'h01, 8'h0D);
        n_vec++;
        if ({tx_en, tx_data} !== {1'b1, 8'h06}) begin
            n_err++;
            $display("FAIL reload_ack: got en=%b data=%h, expected 1 06", tx_en, tx_data);
        end
        d_o_ready = 1'b1;
        start_rd(1'b1);
        hs++;
        tick();
        d_o_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_vec++;
            if ({d_o_valid, d_o, d_o_last} !== {1'b1, 24'h040506, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got v=%b d=%h last=%b, expected 1 040506 0",
                         s, d_o_valid, d_o, d_o_last);
            end
        end
        d_o_ready = 1'b1;
        for (int w = 1; w < 8 && rd_busy; w++) begin
            n_vec++;
            if ({d_o, d_o_last} !== {exp_w[w], (w == 3)}) begin
                n_err++;
                $display("FAIL stall_word%0d: got d=%h last=%b, expected %h %b", w, d_o, d_o_last, exp_w[w], (w == 3));
            end
            if (d_o_valid) hs++;
            tick();
        end
        n_vec++;
        if (hs !== 4 || rd_busy !== 1'b0) begin
            n_err++;
            $display("FAIL stall_total: got %0d words busy=%b, expected 4 words busy=0", hs, rd_busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int k = 0; k < 5; k++) send_byte(8'(k + 1));
        while (!tx_en && n < 1100) begin
            tick();
            n++;
        end
        n_vec++;
        if (n !== 1000) begin
            n_err++;
            $display("FAIL timeout_cycles: got %0d, expected 1000", n);
        end
        n_vec++;
        if ({tx_en, tx_data, frame_err, ch_valid[0]} !== {1'b1, 8'h15, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_nak: got en=%b data=%h ferr=%b cv0=%b, expected 1 15 1 0",
                     tx_en, tx_data, frame_err, ch_valid[0]);
        end
    endtask

    task automatic test_bad_ch_load_en();
        int c0;
        send_byte(8'hA5);
        send_byte(8'h05);
        n_vec++;
        if ({tx_en, tx_data, frame_err} !== {1'b1, 8'h15, 1'b1}) begin
            n_err++;
            $display("FAIL nak_bad_ch: got en=%b data=%h ferr=%b, expected 1 15 1", tx_en, tx_data, frame_err);
        end
        tick();
        c0 = tx_cnt;
        load_en = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        tick();
        n_vec++;
        if (tx_cnt !== c0 || ch_valid !== 2'b10) begin
            n_err++;
            $display("FAIL load_en_gate: got %0d new replies ch_valid=%b, expected 0 10", tx_cnt - c0, ch_valid);
        end
        load_en = 1'b1;
        send_frame(8'h00, 8'h0C);
        n_vec++;
        if ({tx_en, tx_data, ch_valid} !== {1'b1, 8'h06, 2'b11}) begin
            n_err++;
            $display("FAIL ch0_after_gate: got en=%b data=%h cv=%b, expected 1 06 11", tx_en, tx_data, ch_valid);
        end
    endtask

    task automatic test_busy_channel();
        int n;
        n = 0;
        d_o_ready = 1'b0;
        start_rd(1'b1);
        send_byte(8'hA5);
        send_byte(8'h01);
        n_vec++;
        if ({tx_en, tx_data, ch_valid} !== {1'b1, 8'h15, 2'b11}) begin
            n_err++;
            $display("FAIL nak_streaming_ch: got en=%b data=%h cv=%b, expected 1 15 11", tx_en, tx_data, ch_valid);
        end
        send_frame(8'h00, 8'h0C);
        n_vec++;
        if ({tx_en, tx_data, ch_valid} !== {1'b1, 8'h06, 2'b11}) begin
            n_err++;
            $display("FAIL load_other_ch: got en=%b data=%h cv=%b, expected 1 06 11", tx_en, tx_data, ch_valid);
        end
        start_rd(1'b0);
        n_vec++;
        if ({rd_busy, d_o_valid, d_o} !== {1'b1, 1'b1, 24'h010203}) begin
            n_err++;
            $display("FAIL rd_start_while_busy: got busy=%b v=%b d=%h, expected 1 1 010203", rd_busy, d_o_valid, d_o);
        end
        d_o_ready = 1'b1;
        while (rd_busy && n < 20) begin
            tick();
            n++;
        end
        n_vec++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL drain_cycles: got %0d, expected 4", n);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        load_en   = 1'b1;
        rx_data   = '0;
        rx_finish = 1'b0;
        rd_start  = 1'b0;
        rd_ch     = '0;
        d_o_ready = 1'b0;
        test_reset();
        test_load_stream();
        test_bad_csum();
        test_stall();
        test_timeout();
        test_bad_ch_load_en();
        test_busy_channel();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
